// File: rtl/div_pkg.sv
// div_pkg: shared constants and types for the iterative divider.
//   - REG_W / ZERO_WORD : register data width and the all-zero word
//   - div_state_e       : divider FSM encodings (2 bits)
//   - ready / start     : named result-valid and request levels
//   - cond_neg()        : optional two's-complement negation
package div_pkg;

   localparam int unsigned REG_W = 32;
   localparam int unsigned CNT_W = 6;

   localparam logic [REG_W-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_e;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

   // Quotient bits retired per operation: one per cycle.
   localparam logic [CNT_W-1:0] DIV_ITERS = 6'd32;

   function automatic logic [REG_W-1:0] cond_neg(input logic neg,
                                                 input logic [REG_W-1:0] v);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div.sv
// div: iterative restoring divider for DIV / DIVU, one quotient bit per cycle.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   signed_div_i  1 = DIV (two's complement), 0 = DIVU; sampled with start_i
//   opdata1_i     dividend; sampled with start_i
//   opdata2_i     divisor;  sampled with start_i
//   start_i       request, held until ready_o is seen
//   annul_i       abandons any operation in progress
//   result_o      {remainder, quotient}; zero unless ready_o=1
//   ready_o       result valid
//
// Signed operands are divided as magnitudes and the signs are fixed up at
// the end: the quotient is negative when the operand signs differ, the
// remainder follows the dividend. Division by zero yields 0.
module div
   import div_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [REG_W-1:0]     opdata1_i,
   input  logic [REG_W-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*REG_W-1:0]   result_o,
   output logic                 ready_o
);

   div_state_e         state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [REG_W-1:0]   dvd;       // remaining dividend bits, MSB first
   logic [REG_W-1:0]   dvs;       // divisor magnitude
   logic [REG_W-1:0]   part;      // partial remainder
   logic [REG_W-1:0]   quo;       // quotient being assembled
   logic               neg_q, neg_r;

   logic [REG_W:0]     part_sh;
   logic [REG_W:0]     trial;
   logic               req;

   assign req = (start_i == DIV_START) && !annul_i;

   // Partial remainder stays below the divisor, so the shifted value fits
   // 33 bits and trial[32] is a reliable borrow/sign bit.
   assign part_sh = {part, dvd[REG_W-1]};
   assign trial   = part_sh - {1'b0, dvs};

   always_ff @(posedge clk) begin
      if (rst) state <= DIV_FREE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         DIV_FREE: begin
            if (req)
               state_nxt = (opdata2_i == ZERO_WORD) ? DIV_BY_ZERO : DIV_ON;
         end
         DIV_BY_ZERO: state_nxt = DIV_END;
         DIV_ON: begin
            if (annul_i)               state_nxt = DIV_FREE;
            else if (cnt == DIV_ITERS) state_nxt = DIV_END;
         end
         DIV_END: begin
            if (start_i == DIV_STOP || annul_i) state_nxt = DIV_FREE;
         end
         default: state_nxt = DIV_FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         dvd      <= ZERO_WORD;
         dvs      <= ZERO_WORD;
         part     <= ZERO_WORD;
         quo      <= ZERO_WORD;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= '0;
         ready_o  <= DIV_RESULT_NOT_READY;
      end else begin
         case (state)
            DIV_FREE: begin
               result_o <= '0;
               ready_o  <= DIV_RESULT_NOT_READY;
               if (req && opdata2_i != ZERO_WORD) begin
                  cnt   <= '0;
                  part  <= ZERO_WORD;
                  quo   <= ZERO_WORD;
                  dvd   <= cond_neg(signed_div_i & opdata1_i[REG_W-1], opdata1_i);
                  dvs   <= cond_neg(signed_div_i & opdata2_i[REG_W-1], opdata2_i);
                  neg_q <= signed_div_i & (opdata1_i[REG_W-1] ^ opdata2_i[REG_W-1]);
                  neg_r <= signed_div_i & opdata1_i[REG_W-1];
               end
            end
            DIV_BY_ZERO: begin
               result_o <= '0;
               ready_o  <= DIV_RESULT_READY;
            end
            DIV_ON: begin
               if (annul_i) begin
                  result_o <= '0;
                  ready_o  <= DIV_RESULT_NOT_READY;
               end else if (cnt == DIV_ITERS) begin
                  result_o <= {cond_neg(neg_r, part), cond_neg(neg_q, quo)};
                  ready_o  <= DIV_RESULT_READY;
               end else begin
                  dvd <= {dvd[REG_W-2:0], 1'b0};
                  if (!trial[REG_W]) begin
                     part <= trial[REG_W-1:0];
                     quo  <= {quo[REG_W-2:0], 1'b1};
                  end else begin
                     part <= part_sh[REG_W-1:0];
                     quo  <= {quo[REG_W-2:0], 1'b0};
                  end
                  cnt <= cnt + 1'b1;
               end
            end
            DIV_END: begin
               if (start_i == DIV_STOP || annul_i) begin
                  result_o <= '0;
                  ready_o  <= DIV_RESULT_NOT_READY;
               end
            end
            default: begin
               result_o <= '0;
               ready_o  <= DIV_RESULT_NOT_READY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
// tb_div: directed self-checking bench for the iterative divider.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i, opdata2_i;
   logic        start_i, annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_chk  = 0;
   int n_fail = 0;

   div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and follow it to completion.
   //   exp_n : edges after the sampling edge until ready_o is seen
   //   hold  : extra cycles start_i stays high after ready_o rises
   //   scram : scribble on the operands while the divider is running
   task automatic run_op(input string tag, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_n, input logic [63:0] exp_r,
                         input int hold, input bit scram);
      int n;
      signed_div_i = sg;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      tick();                        // sampling edge k
      if (scram) begin
         opdata1_i    = 32'h1234_5678;
         opdata2_i    = 32'h0000_0000;
         signed_div_i = ~sg;
      end
      n = 0;
      while (!ready_o && n < 100) begin
         chk({tag, " early_result"}, result_o, 64'h0);
         tick();
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'(exp_n));
      chk({tag, " result"}, result_o, exp_r);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, " hold_ready"}, {63'h0, ready_o}, 64'h1);
         chk({tag, " hold_result"}, result_o, exp_r);
      end
      start_i = 1'b0;
      tick();
      chk({tag, " drop_ready"}, {63'h0, ready_o}, 64'h0);
      chk({tag, " drop_result"}, result_o, 64'h0);
   endtask

   initial begin
      int seen;
      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
      opdata1_i = '0; opdata2_i = '0;
      tick(); tick();
      chk("reset ready", {63'h0, ready_o}, 64'h0);
      chk("reset result", result_o, 64'h0);
      rst = 1'b0;
      tick();

      // 33 edges after the sampling edge for a real division, 1 for /0.
      run_op("u100/7",   1'b0, 32'd100,      32'd7,          33, {32'h2, 32'hE}, 0, 1'b0);
      run_op("s-7/2",    1'b1, 32'hFFFF_FFF9, 32'd2,         33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 1'b0);
      run_op("s7/-2",    1'b1, 32'd7,        32'hFFFF_FFFE,  33, {32'h1, 32'hFFFF_FFFD}, 0, 1'b0);
      run_op("s-100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, {32'hFFFF_FFFE, 32'hE}, 0, 1'b0);
      run_op("u/0",      1'b0, 32'hDEAD_BEEF, 32'd0,         1,  64'h0, 0, 1'b0);
      run_op("s/0",      1'b1, 32'h8000_0001, 32'd0,         1,  64'h0, 0, 1'b0);
      run_op("uFFFF/1",  1'b0, 32'hFFFF_FFFF, 32'd1,         33, {32'h0, 32'hFFFF_FFFF}, 0, 1'b0);
      run_op("uFFFF/16", 1'b0, 32'hFFFF_FFFF, 32'd16,        33, {32'hF, 32'h0FFF_FFFF}, 0, 1'b0);
      run_op("s_min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0, 32'h8000_0000}, 0, 1'b0);
      run_op("u1000/3_hold", 1'b0, 32'd1000, 32'd3,          33, {32'h1, 32'd333}, 5, 1'b0);
      run_op("u100/7_scram", 1'b0, 32'd100,  32'd7,          33, {32'h2, 32'hE}, 0, 1'b1);

      // Annul during iteration 10: result must never appear.
      signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) tick();
      annul_i = 1'b1; start_i = 1'b0;
      tick();
      annul_i = 1'b0;
      chk("annul ready", {63'h0, ready_o}, 64'h0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ready_o || result_o != 64'h0) seen++;
      end
      chk("annul no_result", 64'(seen), 64'h0);
      run_op("after_annul 9/3", 1'b0, 32'd9, 32'd3, 33, {32'h0, 32'h3}, 0, 1'b0);

      // Reset in the middle of an operation.
      signed_div_i = 1'b1; opdata1_i = 32'hFFFF_FFF9; opdata2_i = 32'd2; start_i = 1'b1;
      tick();
      for (int i = 0; i < 15; i++) tick();
      rst = 1'b1; start_i = 1'b0;
      tick();
      chk("rst_mid ready", {63'h0, ready_o}, 64'h0);
      chk("rst_mid result", result_o, 64'h0);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ready_o || result_o != 64'h0) seen++;
      end
      chk("rst_mid quiet", 64'(seen), 64'h0);
      run_op("after_rst 100/7", 1'b0, 32'd100, 32'd7, 33, {32'h2, 32'hE}, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
